spi_sipo_rx: RTL and testbench
==============================

# spi_sipo_rx

Serial-in/parallel-out receive stage for the SPI datapath: it consumes the MSB-first serial bit stream produced by the transmit shifter and reassembles it into parallel words. Completed words are handed to downstream logic through a holding register with a valid/ready handshake. Overrun and aborted-frame conditions are flagged. It runs on the same `clock` as the transmit shifter and samples one bit per qualified cycle.

## Interface

**Parameters**

- `DATA_W`, default 8: word width in bits.
- `MSB_FIRST`, default 1: bit order.
  - 1: the first received bit lands in `out_data[DATA_W-1]`.
  - 0: the first received bit lands in `out_data[0]`.

**Ports**

- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_en` in 1: frame-active qualifier; when high, `serial_in` carries a valid bit this cycle.
- `serial_in` in 1: serial data bit.
- `clr_overrun` in 1: when high, clears the sticky `overrun` flag.
- `out_ready` in 1: the downstream consumer accepts `out_data` this cycle.
- `out_data` out `DATA_W`: last completed word, held stable while `out_valid` is high.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `overrun` out 1: sticky; a completed word was dropped because the holding register was full.
- `frame_abort` out 1: one-cycle pulse; `rx_en` fell mid-word.
- `bit_count` out `$clog2(DATA_W)`: number of bits captured in the current partial word.

## Operation

**Reset**

While `reset` is high on an edge, the following are cleared to 0: `out_data`, `out_valid`, `overrun`, `frame_abort`, `bit_count`, and the shift register. The state machine goes to IDLE. Reset overrides every other input.

**State machine**

- **IDLE**
  - `rx_en=1`: capture `serial_in` as bit 0 of the word, set `bit_count=1`, go to SHIFT.
  - `rx_en=0`: stay in IDLE.
- **SHIFT**
  - `rx_en=1`, `bit_count<DATA_W-1`: shift in `serial_in`, increment `bit_count`.
  - `rx_en=1`, `bit_count==DATA_W-1`: word completes this edge.
    - Perform the handoff described below.
    - Set `bit_count=0` and stay in SHIFT, so a back-to-back next word starts on the following qualified cycle with no gap.
  - `rx_en=0`: discard the partial word, pulse `frame_abort` for one cycle, set `bit_count=0`, go to IDLE.

**Bit placement**

- `MSB_FIRST=1`: shift left, with the new bit entering at the LSB.
- `MSB_FIRST=0`: shift right, with the new bit entering at the MSB.

**Handoff on word completion**

The completed word is the shift register contents plus the current bit.

- If `out_valid=0`, or if `out_valid=1` and `out_ready=1` on the same edge: load `out_data` and set `out_valid=1`.
- Otherwise: drop the word, keep the old `out_data` unchanged, and set `overrun=1`.

**Consumption**

- If `out_valid=1`, `out_ready=1`, and no word completes on that edge, `out_valid` goes to 0.
- `out_data` retains its last value after consumption.

**overrun flag**

- Cleared only by `reset` or by `clr_overrun=1`.
- If `clr_overrun=1` and a new overrun occur on the same edge, the set wins and `overrun` ends at 1.

**Abort corner case**

`rx_en` falling on the cycle immediately after a word completes (`bit_count==0`) is not an abort. The state machine returns to IDLE silently and `frame_abort` does not pulse.

## Timing

- One bit is sampled per rising edge on which `rx_en=1`; `rx_en` must be aligned with `serial_in`.
- Latency: `out_valid` rises on the same edge that samples the `DATA_W`-th bit, so it is visible in the following cycle.
- Sustained throughput is one word per `DATA_W` qualified cycles, provided `out_ready` is high when each word completes.
- `out_ready` has no effect while `out_valid=0`.
- `frame_abort` is high for exactly one cycle, the cycle after the edge that detected the abort.
- `reset` asserted mid-word discards the partial word and any held word, and returns to IDLE on that edge.
- No combinational path exists from any input to any output; all outputs are registered.

## Test plan

1. **Single word:** reset; `rx_en=1` for 8 cycles with `serial_in` = 1,0,1,0,0,1,0,1 (`MSB_FIRST=1`).
   - On the edge after the 8th bit: `out_data=8'hA5`, `out_valid=1`, `bit_count=0`.
   - After `out_ready=1` for one cycle: `out_valid=0`.
2. **Back-to-back words:** 16 continuous bits encoding 8'h3C then 8'hC3, with `out_ready` held at 1.
   - `out_valid` pulses twice, 8 cycles apart.
   - `out_data` reads 3C, then C3.
   - `overrun` stays 0.
3. **Overrun:** receive 8'h11 with `out_ready=0`, then receive 8'h22.
   - `out_data` stays 8'h11 and `out_valid` stays 1.
   - `overrun=1` after the 16th bit.
   - `clr_overrun` pulsed for one cycle: `overrun=0`.
4. **Mid-frame abort:** drop `rx_en` after 5 bits.
   - `frame_abort` is high for exactly one cycle.
   - `bit_count=0`, `out_valid` remains 0.
   - A following full word 8'h5A is received correctly.
5. **Reset mid-word:** assert `reset` for one cycle after 3 bits, with a word already held.
   - All outputs are 0 the next cycle.
   - A following word 8'hFF is received intact.
6. **LSB-first:** with `MSB_FIRST=0`, send bits 1,0,0,0,0,0,0,0 → `out_data=8'h01`.
7. **Random (recommended):** loop the transmit shifter's output into this block for random bytes and compare each received word against the transmitted one.

Source files
------------

// File: rtl/spi_sipo_rx.sv
// Serial-in/parallel-out SPI receive stage: assembles qualified serial bits into
// words and hands them downstream through a valid/ready holding register.
module spi_sipo_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_en,
  input  logic                      serial_in,
  input  logic                      clr_overrun,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      overrun,
  output logic                      frame_abort,
  output logic [$clog2(DATA_W)-1:0] bit_count
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              abort_q, abort_d;
  logic              word_done_s;
  logic [DATA_W-1:0] word_s;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    logic [DATA_W-1:0] res;
    if (MSB_FIRST != 1'b0) begin
      res = {cur[DATA_W-2:0], b};
    end else begin
      res = {b, cur[DATA_W-1:1]};
    end
    return res;
  endfunction

  // State register and output flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state: bit capture, word completion, handoff and flag updates
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = (clr_overrun == 1'b1) ? 1'b0 : overrun_q;
    abort_d     = 1'b0;
    word_done_s = 1'b0;
    word_s      = shift_in(shift_q, serial_in);

    case (state_q)
      IDLE: begin
        if (rx_en) begin
          shift_d = shift_in({DATA_W{1'b0}}, serial_in);
          count_d = CW'(1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (rx_en) begin
          if (count_q == LAST_BIT) begin
            word_done_s = 1'b1;
            shift_d     = '0;
            count_d     = '0;
          end else begin
            shift_d = word_s;
            count_d = count_q + CW'(1);
          end
        end else begin
          // A zero count means the previous word just completed: not an abort.
          abort_d = (count_q != '0);
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        count_d = '0;
      end
    endcase

    if (word_done_s) begin
      if (!valid_q || out_ready) begin
        data_d  = word_s;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign overrun     = overrun_q;
  assign frame_abort = abort_q;
  assign bit_count   = count_q;

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Self-checking bench for spi_sipo_rx: a vector table, directed corner sequences and
// random traffic compared against a bit-queue reference model.
module tb_spi_sipo_rx;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         rx_en = 1'b0;
  logic         serial_in = 1'b0;
  logic         clr_overrun = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data, out_data_l;
  logic         out_valid, overrun, frame_abort;
  logic         out_valid_l, overrun_l, frame_abort_l;
  logic [2:0]   bit_count, bit_count_l;

  int n_checks = 0;
  int n_pass   = 0;

  spi_sipo_rx #(.DATA_W(W), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .rx_en(rx_en), .serial_in(serial_in),
    .clr_overrun(clr_overrun), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .overrun(overrun), .frame_abort(frame_abort),
    .bit_count(bit_count)
  );

  spi_sipo_rx #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .rx_en(rx_en), .serial_in(serial_in),
    .clr_overrun(clr_overrun), .out_ready(out_ready), .out_data(out_data_l),
    .out_valid(out_valid_l), .overrun(overrun_l), .frame_abort(frame_abort_l),
    .bit_count(bit_count_l)
  );

  always #5 clock = ~clock;

  // Reference model: received bits are kept in a queue; a word is formed when it holds W bits.
  bit           m_q[$];
  logic [W-1:0] m_data_m = '0;
  logic [W-1:0] m_data_l = '0;
  bit           m_valid = 1'b0;
  bit           m_ov = 1'b0;
  bit           m_fa = 1'b0;

  task automatic model_edge(input bit r, input bit en, input bit s, input bit clr, input bit rdy);
    bit           done = 1'b0;
    bit           ov_set = 1'b0;
    logic [W-1:0] wm = '0;
    logic [W-1:0] wl = '0;
    if (r) begin
      m_q.delete();
      m_data_m = '0; m_data_l = '0;
      m_valid = 1'b0; m_ov = 1'b0; m_fa = 1'b0;
    end else begin
      m_fa = 1'b0;
      if (en) begin
        m_q.push_back(s);
        if (m_q.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm = wm | (W'(m_q[i]) << (W - 1 - i));
            wl = wl | (W'(m_q[i]) << i);
          end
          m_q.delete();
        end
      end else begin
        if (m_q.size() > 0) m_fa = 1'b1;
        m_q.delete();
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_data_m = wm; m_data_l = wl; m_valid = 1'b1;
        end else begin
          ov_set = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_ov = (m_ov && !clr) || ov_set;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit r, input bit en, input bit s, input bit clr, input bit rdy);
    reset = r; rx_en = en; serial_in = s; clr_overrun = clr; out_ready = rdy;
    model_edge(r, en, s, clr, rdy);
    @(posedge clock);
    #1;
  endtask

  task automatic check_model();
    check("model_data_msb", 32'(out_data), 32'(m_data_m));
    check("model_data_lsb", 32'(out_data_l), 32'(m_data_l));
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_overrun", 32'(overrun), 32'(m_ov));
    check("model_abort", 32'(frame_abort), 32'(m_fa));
    check("model_bit_count", 32'(bit_count), 32'(m_q.size()));
  endtask

  task automatic step(input bit r, input bit en, input bit s, input bit clr, input bit rdy);
    drive(r, en, s, clr, rdy);
    check_model();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, w[W-1-i], 1'b0, rdy);
  endtask

  typedef struct {
    logic         rst, en, sin, clr, rdy;
    logic [W-1:0] data;
    logic         valid, ov, fa;
    logic [2:0]   bc;
  } vec_t;

  vec_t         vecs[11];
  logic [W-1:0] pat;
  logic [W-1:0] rb;

  initial begin
    // Single word 8'hA5, MSB first, then consumed.
    pat = 8'hA5;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
    for (int i = 0; i < 8; i++) begin
      vecs[i+1] = '{1'b0, 1'b1, pat[7-i], 1'b0, 1'b0,
                    (i == 7) ? 8'hA5 : 8'h00, (i == 7), 1'b0, 1'b0, 3'((i + 1) % 8)};
    end
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].sin, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].ov));
      check($sformatf("vec%0d_abort", i), 32'(frame_abort), 32'(vecs[i].fa));
      check($sformatf("vec%0d_bit_count", i), 32'(bit_count), 32'(vecs[i].bc));
    end

    // Back-to-back words with out_ready held high.
    send_word(8'h3C, 1'b1);
    check("b2b_first_data", 32'(out_data), 32'h3C);
    check("b2b_first_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("b2b_gap_valid", 32'(out_valid), 32'h0);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, rb_bit(8'hC3, i), 1'b0, 1'b1);
    check("b2b_second_data", 32'(out_data), 32'hC3);
    check("b2b_second_valid", 32'(out_valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);

    // Overrun: second word dropped while the first is still held.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("ovr_data", 32'(out_data), 32'h11);
    check("ovr_valid", 32'(out_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_cleared", 32'(overrun), 32'h0);
    check("ovr_still_valid", 32'(out_valid), 32'h1);

    // Mid-frame abort after 5 bits.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_pulse", 32'(frame_abort), 32'h1);
    check("abort_bit_count", 32'(bit_count), 32'h0);
    check("abort_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_one_cycle", 32'(frame_abort), 32'h0);
    send_word(8'h5A, 1'b0);
    check("abort_next_word", 32'(out_data), 32'h5A);

    // Reset mid-word with a word held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_bit_count", 32'(bit_count), 32'h0);
    send_word(8'hFF, 1'b0);
    check("rst_next_word", 32'(out_data), 32'hFF);
    check("rst_next_valid", 32'(out_valid), 32'h1);

    // LSB-first instance: first bit lands in bit 0.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h80, 1'b0);
    check("lsb_first_data", 32'(out_data_l), 32'h01);
    check("msb_first_data", 32'(out_data), 32'h80);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), 1'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    end

    // Loopback of random bytes from an ideal MSB-first transmitter.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      rb = W'($urandom);
      send_word(rb, 1'b1);
      check("loopback_data", 32'(out_data), 32'(rb));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic bit rb_bit(input logic [W-1:0] w, input int i);
    return w[W-1-i];
  endfunction

endmodule
